// File: rtl/mem_bank_port_arbiter_pkg.sv
// Shared helpers for the memory bank port arbiter: tag/index sizing and the
// byte-offset width that separates byte addresses from SRAM word addresses.
package mem_arb_pkg;

    localparam int unsigned ATOP_W = 6;

    function automatic int unsigned offset_width(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // A single port still needs a one-bit index field in the response tag.
    function automatic int unsigned idx_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_bank_port_arbiter_chk.sv
// Protocol checker for the arbiter: one-hot strobes, grant implies request,
// no atomics reaching the SRAM, and legal parameterisation.
module mem_arb_chk
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned SramLatency = 1
) (
    input logic                           clk_i,
    input logic                           rst_i,
    input logic [NumPorts-1:0]            in_req_i,
    input logic [NumPorts-1:0]            in_gnt_o,
    input logic [NumPorts-1:0]            in_rvalid_o,
    input logic [NumPorts-1:0][ATOP_W-1:0] in_atop_i
);

    // Sampled at every edge outside reset.
    always_ff @(posedge clk_i) begin
        assert (SramLatency >= 1 && (DataWidth % 8) == 0)
            else $error("arbiter parameters illegal");
        if (!rst_i) begin
            assert ($onehot0(in_rvalid_o)) else $error("rvalid not one-hot");
            assert ($onehot0(in_gnt_o)) else $error("gnt not one-hot");
            assert ((in_gnt_o & ~in_req_i) == '0) else $error("gnt without req");
            for (int k = 0; k < int'(NumPorts); k++) begin
                assert (!(in_gnt_o[k] && (in_atop_i[k] != '0)))
                    else $error("atomic granted on port %0d", k);
            end
        end else begin
        end
    end

endmodule

// File: rtl/mem_bank_port_arbiter_rsp_tracker.sv
// Fixed-latency response tracker: shifts {valid, port index} tags alongside
// the SRAM pipeline and raises the issuing port's rvalid when data returns.
module mem_rsp_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned SramLatency = 1,
    parameter int unsigned IdxW        = idx_width(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_valid_i,
    input  logic [IdxW-1:0]     push_idx_i,
    input  logic                sram_req_i,
    output logic [NumPorts-1:0] rvalid_o,
    output logic                busy_o
);

    typedef struct packed {
        logic            valid;
        logic [IdxW-1:0] idx;
    } rsp_tag_t;

    rsp_tag_t r_tags [SramLatency];
    logic     w_any_valid;

    // Tag pipeline; reset drops every in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SramLatency); i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_tags[0].valid <= push_valid_i;
            r_tags[0].idx   <= push_idx_i;
            for (int i = 1; i < int'(SramLatency); i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    // Decode the oldest tag into a per-port strobe and reduce busy.
    always_comb begin
        rvalid_o    = '0;
        w_any_valid = 1'b0;
        for (int i = 0; i < int'(SramLatency); i++) begin
            w_any_valid = w_any_valid | r_tags[i].valid;
        end
        if (r_tags[SramLatency-1].valid && !rst_i) begin
            rvalid_o[r_tags[SramLatency-1].idx] = 1'b1;
        end else begin
            rvalid_o = '0;
        end
        busy_o = !rst_i && (sram_req_i || w_any_valid);
    end

endmodule

// File: rtl/mem_bank_port_arbiter.sv
// Round-robin arbiter merging NumPorts req/gnt/rvalid ports onto one
// single-ported SRAM with fixed-latency response routing.
module mem_bank_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned SramLatency = 1,
    parameter int unsigned SramAddrW   = AddrWidth - offset_width(DataWidth)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    output logic                                 busy_o,
    input  logic [NumPorts-1:0]                  in_req_i,
    output logic [NumPorts-1:0]                  in_gnt_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   in_addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   in_wdata_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0] in_strb_i,
    input  logic [NumPorts-1:0][ATOP_W-1:0]      in_atop_i,
    input  logic [NumPorts-1:0]                  in_we_i,
    output logic [NumPorts-1:0]                  in_rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]   in_rdata_o,
    output logic                                 sram_req_o,
    output logic                                 sram_we_o,
    output logic [SramAddrW-1:0]                 sram_addr_o,
    output logic [DataWidth-1:0]                 sram_wdata_o,
    output logic [DataWidth/8-1:0]               sram_be_o,
    input  logic [DataWidth-1:0]                 sram_rdata_i
);

    localparam int unsigned IdxW = idx_width(NumPorts);
    localparam int unsigned OffW = offset_width(DataWidth);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_hi_idx;
    logic [IdxW-1:0] w_any_idx;
    logic [IdxW-1:0] w_win_idx;
    logic [IdxW-1:0] w_next_ptr;
    logic            w_hi_found;
    logic            w_any_found;
    logic            w_win_found;
    logic            w_unused_addr;

    assign w_unused_addr = ^in_addr_i;

    // Lowest requester at/after the pointer, else lowest overall (wrap-around).
    always_comb begin
        w_hi_found  = 1'b0;
        w_hi_idx    = '0;
        w_any_found = 1'b0;
        w_any_idx   = '0;
        for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
            if (in_req_i[k]) begin
                w_any_found = 1'b1;
                w_any_idx   = IdxW'(k);
                if (k >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IdxW'(k);
                end else begin
                    w_hi_found = w_hi_found;
                end
            end else begin
                w_any_found = w_any_found;
            end
        end
        w_win_found = w_any_found && !rst_i;
        w_win_idx   = w_hi_found ? w_hi_idx : w_any_idx;
        if (w_win_idx == IdxW'(NumPorts - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_win_idx + IdxW'(1);
        end
    end

    // Pointer moves past each winner and holds on idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_win_found) begin
            r_ptr <= w_next_ptr;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Grant strobe and SRAM field mux from the winning port; idle drives zero.
    always_comb begin
        in_gnt_o     = '0;
        sram_req_o   = w_win_found;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (w_win_found) begin
            in_gnt_o[w_win_idx] = 1'b1;
            sram_we_o           = in_we_i[w_win_idx];
            sram_addr_o         = in_addr_i[w_win_idx][AddrWidth-1:OffW];
            sram_wdata_o        = in_wdata_i[w_win_idx];
            sram_be_o           = in_strb_i[w_win_idx];
        end else begin
            in_gnt_o = '0;
        end
    end

    // Read data is shared by all ports; rvalid selects the owner.
    always_comb begin
        for (int k = 0; k < int'(NumPorts); k++) begin
            in_rdata_o[k] = sram_rdata_i;
        end
    end

    mem_rsp_tracker #(
        .NumPorts    (NumPorts),
        .SramLatency (SramLatency),
        .IdxW        (IdxW)
    ) u_tracker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (w_win_found),
        .push_idx_i   (w_win_idx),
        .sram_req_i   (w_win_found),
        .rvalid_o     (in_rvalid_o),
        .busy_o       (busy_o)
    );

    mem_arb_chk #(
        .NumPorts    (NumPorts),
        .DataWidth   (DataWidth),
        .SramLatency (SramLatency)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_req_i    (in_req_i),
        .in_gnt_o    (in_gnt_o),
        .in_rvalid_o (in_rvalid_o),
        .in_atop_i   (in_atop_i)
    );

endmodule
